// File: rtl/arcino_trace_buffer.sv
`default_nettype none
// ============================================================================
// arcino_trace_buffer : retire-port trace unit (class decode, counters, FIFO)
// Rev 1.0
// ============================================================================
module arcino_trace_buffer #(
    parameter  int DEPTH = 16,
    parameter  int CNT_W = 32,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode_i,
    input  logic             ret_valid_i,
    input  logic [31:0]      ret_pc_i,
    input  logic [31:0]      ret_instr_i,
    input  logic             ret_br_taken_i,
    output logic             trc_valid_o,
    input  logic             trc_ready_i,
    output logic [31:0]      trc_pc_o,
    output logic [31:0]      trc_instr_o,
    output logic [2:0]       trc_class_o,
    output logic             trc_ovf_o,
    output logic [LVL_W-1:0] fifo_level_o,
    input  logic [2:0]       cnt_sel_i,
    output logic [CNT_W-1:0] cnt_rdata_o,
    output logic [CNT_W-1:0] drop_cnt_o,
    input  logic             cnt_clr_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int NCLS  = 8;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] CLS_ALU    = 3'd0;
    localparam logic [2:0] CLS_BR_NT  = 3'd1;
    localparam logic [2:0] CLS_BR_T   = 3'd2;
    localparam logic [2:0] CLS_JUMP   = 3'd3;
    localparam logic [2:0] CLS_MULDIV = 3'd4;
    localparam logic [2:0] CLS_CSR    = 3'd5;
    localparam logic [2:0] CLS_SYS    = 3'd6;
    localparam logic [2:0] CLS_OTHER  = 3'd7;

    typedef struct packed {
        logic        ovf;
        logic [2:0]  cls;
        logic [31:0] instr;
        logic [31:0] pc;
    } rec_t;

    logic [2:0]       cls;
    logic             push_req;
    logic             push;
    logic             pop;
    logic             drop;
    logic             full;
    logic             empty;
    logic [LVL_W-1:0] level;
    rec_t             push_rec;

    logic [LVL_W-1:0] wr_cnt_d, wr_cnt_q;
    logic [LVL_W-1:0] rd_cnt_d, rd_cnt_q;
    logic             ovf_pend_d, ovf_pend_q;
    logic [CNT_W-1:0] drop_cnt_d, drop_cnt_q;
    rec_t             head_d, head_q;
    rec_t             mem_q [DEPTH];
    logic [CNT_W-1:0] cnt_vals [NCLS];

    always_comb begin
        cls = CLS_OTHER;
        case (ret_instr_i[6:0])
            OPC_LUI, OPC_AUIPC, OPC_OPIMM: cls = CLS_ALU;
            OPC_OP:     cls = (ret_instr_i[31:25] == 7'b0000001) ? CLS_MULDIV : CLS_ALU;
            OPC_BRANCH: cls = ret_br_taken_i ? CLS_BR_T : CLS_BR_NT;
            OPC_JAL, OPC_JALR: cls = CLS_JUMP;
            OPC_SYSTEM: cls = (ret_instr_i[14:12] != 3'b000) ? CLS_CSR : CLS_SYS;
            default:    cls = CLS_OTHER;
        endcase
    end

    always_comb begin
        push_req = ret_valid_i &
                   ((mode_i == 2'b01) |
                    ((mode_i == 2'b10) & ((cls == CLS_BR_T) | (cls == CLS_JUMP) | (cls == CLS_SYS))));
        level    = wr_cnt_q - rd_cnt_q;
        full     = (level == LVL_W'(DEPTH));
        empty    = (level == '0);
        pop      = ~empty & trc_ready_i;
        // A full FIFO still accepts when the head leaves in the same cycle.
        push     = push_req & (~full | pop);
        drop     = push_req & full & ~pop;
        push_rec = '{ovf: ovf_pend_q, cls: cls, instr: ret_instr_i, pc: ret_pc_i};
        wr_cnt_d = wr_cnt_q + LVL_W'(push);
        rd_cnt_d = rd_cnt_q + LVL_W'(pop);
    end

    always_comb begin
        ovf_pend_d = ovf_pend_q;
        if (push) begin
            ovf_pend_d = 1'b0;
        end else if (drop) begin
            ovf_pend_d = 1'b1;
        end
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (cnt_clr_i) begin
            drop_cnt_d = '0;
        end else if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // Head register: next head is either an existing slot or the record being
    // written this cycle; it holds its value whenever the FIFO goes empty.
    always_comb begin
        head_d = head_q;
        if (wr_cnt_d != rd_cnt_d) begin
            if (push && (wr_cnt_q[PTR_W-1:0] == rd_cnt_d[PTR_W-1:0])) begin
                head_d = push_rec;
            end else begin
                head_d = mem_q[rd_cnt_d[PTR_W-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_cnt_q[PTR_W-1:0]] <= push_rec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            ovf_pend_q <= 1'b0;
            drop_cnt_q <= '0;
            head_q     <= '0;
        end else begin
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            ovf_pend_q <= ovf_pend_d;
            drop_cnt_q <= drop_cnt_d;
            head_q     <= head_d;
        end
    end

    for (genvar g = 0; g < NCLS; g++) begin : g_cnt
        logic [CNT_W-1:0] cnt_d, cnt_q;

        always_comb begin
            cnt_d = cnt_q;
            if (cnt_clr_i) begin
                cnt_d = '0;
            end else if (ret_valid_i && (cls == 3'(g)) && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign cnt_vals[g] = cnt_q;
    end

    assign trc_valid_o  = ~empty;
    assign trc_pc_o     = head_q.pc;
    assign trc_instr_o  = head_q.instr;
    assign trc_class_o  = head_q.cls;
    assign trc_ovf_o    = head_q.ovf;
    assign fifo_level_o = level;
    assign cnt_rdata_o  = cnt_vals[cnt_sel_i];
    assign drop_cnt_o   = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_arcino_trace_buffer.sv
`default_nettype none
// ============================================================================
// tb_arcino_trace_buffer : directed table, corner sequences and random traffic
// Rev 1.0
// ============================================================================
module tb_arcino_trace_buffer;

    localparam int DEPTH = 16;
    localparam int CNT_W = 32;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic             ret_valid = 1'b0;
    logic [31:0]      ret_pc = '0;
    logic [31:0]      ret_instr = '0;
    logic             ret_br_taken = 1'b0;
    logic             trc_ready = 1'b0;
    logic [2:0]       cnt_sel = '0;
    logic             cnt_clr = 1'b0;
    logic             trc_valid;
    logic [31:0]      trc_pc;
    logic [31:0]      trc_instr;
    logic [2:0]       trc_class;
    logic             trc_ovf;
    logic [LVL_W-1:0] fifo_level;
    logic [CNT_W-1:0] cnt_rdata;
    logic [CNT_W-1:0] drop_cnt;

    always #5 clk = ~clk;

    arcino_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .mode_i(mode),
        .ret_valid_i(ret_valid), .ret_pc_i(ret_pc), .ret_instr_i(ret_instr),
        .ret_br_taken_i(ret_br_taken),
        .trc_valid_o(trc_valid), .trc_ready_i(trc_ready),
        .trc_pc_o(trc_pc), .trc_instr_o(trc_instr), .trc_class_o(trc_class),
        .trc_ovf_o(trc_ovf), .fifo_level_o(fifo_level),
        .cnt_sel_i(cnt_sel), .cnt_rdata_o(cnt_rdata), .drop_cnt_o(drop_cnt),
        .cnt_clr_i(cnt_clr)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [2:0]  cls;
        logic        ovf;
    } rec_t;

    typedef struct {
        logic [1:0]  mode;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        tk;
        logic        rdy;
        logic        clr;
        logic [2:0]  sel;
        logic        e_valid;
        int          e_level;
        logic [31:0] e_pc;
        logic [2:0]  e_cls;
        int          e_cnt;
    } vec_t;

    int checks = 0;
    int errors = 0;

    rec_t        q[$];
    rec_t        last;
    int unsigned m_cnt [8];
    int unsigned m_drop;
    bit          m_ovfp;

    logic [31:0] pool [20];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] m_class(input logic [31:0] ins, input logic tk);
        case (ins[6:0])
            7'h37, 7'h17, 7'h13: return 3'd0;
            7'h33:               return (ins[31:25] == 7'b0000001) ? 3'd4 : 3'd0;
            7'h63:               return tk ? 3'd2 : 3'd1;
            7'h6F, 7'h67:        return 3'd3;
            7'h73:               return (ins[14:12] != 3'b000) ? 3'd5 : 3'd6;
            default:             return 3'd7;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        last   = '{pc: '0, instr: '0, cls: '0, ovf: 1'b0};
        m_drop = 0;
        m_ovfp = 1'b0;
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    endtask

    task automatic check_model();
        chk("valid", trc_valid, q.size() != 0);
        chk("level", fifo_level, q.size());
        chk("drop_cnt", drop_cnt, m_drop);
        chk("cnt_rdata", cnt_rdata, m_cnt[cnt_sel]);
        chk("head_pc", trc_pc, last.pc);
        chk("head_instr", trc_instr, last.instr);
        chk("head_class", trc_class, last.cls);
        chk("head_ovf", trc_ovf, last.ovf);
    endtask

    // One clock: model evaluates the inputs presented before the edge,
    // then DUT and model are compared just after the edge.
    task automatic cycle();
        logic [2:0] c;
        bit         pop, req, full, acc, dropped;
        rec_t       tmp;
        c       = m_class(ret_instr, ret_br_taken);
        full    = (q.size() == DEPTH);
        pop     = (q.size() != 0) && trc_ready;
        req     = ret_valid && (mode == 2'b01 ||
                  (mode == 2'b10 && (c == 3'd2 || c == 3'd3 || c == 3'd6)));
        acc     = req && (!full || pop);
        dropped = req && full && !pop;
        @(posedge clk);
        #1;
        if (pop) tmp = q.pop_front();
        if (acc) begin
            q.push_back('{pc: ret_pc, instr: ret_instr, cls: c, ovf: m_ovfp});
            m_ovfp = 1'b0;
        end
        if (dropped) begin
            m_ovfp = 1'b1;
            if (m_drop != 32'hFFFF_FFFF) m_drop++;
        end
        if (cnt_clr) begin
            m_drop = 0;
            for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        end else if (ret_valid && m_cnt[c] != 32'hFFFF_FFFF) begin
            m_cnt[c]++;
        end
        if (q.size() != 0) last = q[0];
        check_model();
    endtask

    task automatic do_reset();
        ret_valid = 1'b0;
        cnt_clr   = 1'b0;
        rst_n     = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", trc_valid, 1'b0);
        chk("rst_level", fifo_level, 0);
        chk("rst_pc", trc_pc, 0);
        chk("rst_instr", trc_instr, 0);
        chk("rst_class", trc_class, 0);
        chk("rst_ovf", trc_ovf, 0);
        chk("rst_drop", drop_cnt, 0);
        for (int i = 0; i < 8; i++) begin
            cnt_sel = 3'(i);
            #1;
            chk("rst_cnt", cnt_rdata, 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    vec_t tbl [10];

    initial begin
        tbl[0] = '{2'b01, 1'b1, 32'h100, 32'h00208033, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1, 32'h100, 3'd0, 1};
        tbl[1] = '{2'b01, 1'b1, 32'h104, 32'h00000063, 1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 1, 32'h104, 3'd2, 1};
        tbl[2] = '{2'b01, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 0, 32'h104, 3'd2, 1};
        tbl[3] = '{2'b00, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 0, 32'h104, 3'd2, 0};
        tbl[4] = '{2'b10, 1'b1, 32'h200, 32'h00100093, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 0, 32'h104, 3'd2, 1};
        tbl[5] = '{2'b10, 1'b1, 32'h204, 32'h00001063, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 0, 32'h104, 3'd2, 1};
        tbl[6] = '{2'b10, 1'b1, 32'h208, 32'h0000006F, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1, 32'h208, 3'd3, 1};
        tbl[7] = '{2'b10, 1'b1, 32'h20C, 32'h30200073, 1'b0, 1'b0, 1'b0, 3'd6, 1'b1, 2, 32'h208, 3'd3, 1};
        tbl[8] = '{2'b10, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1, 32'h20C, 3'd6, 1};
        tbl[9] = '{2'b00, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 0, 32'h20C, 3'd6, 1};

        pool = '{32'h00208033, 32'h40208033, 32'h02208033, 32'h0220C033, 32'h000010B7,
                 32'h00001097, 32'h00100093, 32'h00000063, 32'h00001063, 32'h0000006F,
                 32'h00008067, 32'h00000073, 32'h00100073, 32'h30200073, 32'h10500073,
                 32'h30529073, 32'h0000A083, 32'h0010A023, 32'h0000000F, 32'h7B200073};

        do_reset();

        // Directed full-mode and flow-only rows
        for (int i = 0; i < 10; i++) begin
            mode = tbl[i].mode;   ret_valid = tbl[i].vld;  ret_pc = tbl[i].pc;
            ret_instr = tbl[i].instr; ret_br_taken = tbl[i].tk;
            trc_ready = tbl[i].rdy; cnt_clr = tbl[i].clr;  cnt_sel = tbl[i].sel;
            cycle();
            chk("tbl_valid", trc_valid, tbl[i].e_valid);
            chk("tbl_level", fifo_level, tbl[i].e_level);
            chk("tbl_pc", trc_pc, tbl[i].e_pc);
            chk("tbl_class", trc_class, tbl[i].e_cls);
            chk("tbl_cnt", cnt_rdata, tbl[i].e_cnt);
        end
        ret_valid = 1'b0;
        cnt_clr   = 1'b0;

        // Overflow: 18 retires into a stalled FIFO, then drain with one more retire
        mode = 2'b01; trc_ready = 1'b0; ret_instr = 32'h00208033; ret_br_taken = 1'b0;
        for (int i = 0; i < 18; i++) begin
            ret_valid = 1'b1;
            ret_pc    = 32'h1000 + 32'(4 * i);
            cycle();
        end
        chk("ovf_level", fifo_level, 16);
        chk("ovf_drop", drop_cnt, 2);
        trc_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            ret_valid = (k == 0);
            ret_pc    = 32'h2000;
            chk("ovf_head_valid", trc_valid, 1'b1);
            chk("ovf_flag", trc_ovf, (k == 16));
            chk("ovf_order_pc", trc_pc, (k == 16) ? 32'h2000 : 32'h1000 + 32'(4 * k));
            cycle();
        end
        chk("ovf_empty", trc_valid, 1'b0);

        // Counter clear beats a same-cycle DIV retire
        mode = 2'b00; ret_valid = 1'b1; ret_instr = 32'h0220C033; cnt_sel = 3'd4; cnt_clr = 1'b1;
        cycle();
        chk("clr_div_cnt", cnt_rdata, 0);
        chk("clr_drop", drop_cnt, 0);
        cnt_clr = 1'b0;
        cycle();
        chk("div_after_clr", cnt_rdata, 1);
        ret_valid = 1'b0;

        // Randomised traffic against the model, with one reset mid-stream
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            mode         = 2'($urandom_range(0, 3));
            ret_valid    = ($urandom_range(0, 3) != 0);
            ret_pc       = $urandom;
            ret_instr    = ($urandom_range(0, 9) == 0) ? $urandom : pool[$urandom_range(0, 19)];
            ret_br_taken = 1'($urandom_range(0, 1));
            trc_ready    = ((i / 60) % 2 == 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
            cnt_clr      = ($urandom_range(0, 63) == 0);
            cnt_sel      = 3'($urandom_range(0, 7));
            cycle();
        end
        cnt_clr = 1'b0;

        // Full FIFO with simultaneous push and pop
        mode = 2'b01; trc_ready = 1'b0; ret_valid = 1'b1; ret_instr = 32'h00000063; ret_br_taken = 1'b1;
        for (int i = 0; i < 40 && q.size() < DEPTH; i++) begin
            ret_pc = 32'h3000 + 32'(4 * i);
            cycle();
        end
        chk("full_level", fifo_level, 16);
        begin
            int unsigned saved_drop;
            saved_drop = m_drop;
            trc_ready  = 1'b1;
            for (int i = 0; i < 5; i++) begin
                ret_pc = 32'h4000 + 32'(4 * i);
                cycle();
                chk("pp_level", fifo_level, 16);
                chk("pp_drop", drop_cnt, saved_drop);
            end
        end

        // Reset with a full FIFO
        trc_ready = 1'b0;
        do_reset();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
